// File: rtl/hazard_control_unit_pkg.sv
// Shared types for the stall/flush hazard unit: halt FSM encoding, tracking-slot record, zero-register constant.
package hazard_control_unit_pkg;

    // Slots store register numbers zero-extended to this width; REG_W must not exceed it.
    localparam int unsigned HZD_REG_W_MAX = 8;

    localparam logic [HZD_REG_W_MAX-1:0] REG_ZERO = '0;

    typedef enum logic [1:0] {
        HALT_RUN    = 2'd0,
        HALT_DRAIN  = 2'd1,
        HALT_HALTED = 2'd2
    } halt_state_t;

    typedef struct packed {
        logic                     v;
        logic [HZD_REG_W_MAX-1:0] rd;
        logic                     load;
    } hzd_slot_t;

    function automatic logic slot_writes(input hzd_slot_t s, input logic [HZD_REG_W_MAX-1:0] r);
        return s.v && (s.rd != REG_ZERO) && (s.rd == r);
    endfunction

endpackage

// File: rtl/hazard_control_unit_track_slot.sv
// One in-flight writer tracking slot: holds on i_hold, loads a bubble on i_bubble, else captures i_slot.
module hazard_track_slot
    import hazard_control_unit_pkg::*;
(
    input  logic      i_clk,
    input  logic      i_reset,
    input  logic      i_hold,
    input  logic      i_bubble,
    input  hzd_slot_t i_slot,
    output hzd_slot_t o_slot
);

    hzd_slot_t slot_q;
    hzd_slot_t slot_d;

    always_comb begin
        slot_d = slot_q;
        if (!i_hold) begin
            slot_d = i_bubble ? '0 : i_slot;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            slot_q <= '0;
        end else begin
            slot_q <= slot_d;
        end
    end

    assign o_slot = slot_q;

endmodule

// File: rtl/hazard_control_unit.sv
// Stall/flush hazard control: load-use stall, multi-cycle load wait, branch flush, debug halt drain.
// Optional stall/flush statistics counters are built when HAZARD_STATS_EN is defined.
module hazard_control_unit
    import hazard_control_unit_pkg::*;
#(
    parameter int unsigned MEM_LAT = 1,
    parameter int unsigned REG_W   = 5
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_issue_valid,
    input  logic [REG_W-1:0] i_rs_ID,
    input  logic [REG_W-1:0] i_rt_ID,
    input  logic             i_use_rs,
    input  logic             i_use_rt,
    input  logic             i_reg_wr_en_ID,
    input  logic [REG_W-1:0] i_reg_sel_ID,
    input  logic             i_is_load_ID,
    input  logic             i_branch_taken_EX,
    input  logic             i_halt_req,
    output logic             o_stall_ID,
    output logic             o_stall_all,
    output logic             o_flush_IF_ID,
    output logic             o_flush_ID_EX,
    output logic             o_fetch_hold,
    output logic             o_halt_ack
`ifdef HAZARD_STATS_EN
    ,
    output logic [31:0]      o_stall_cycles,
    output logic [31:0]      o_flush_count
`endif
);

    localparam int NSLOT  = 3;
    localparam int S_EX   = 0;
    localparam int S_MEM  = 1;
    localparam int S_WB   = 2;
    localparam int WAIT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

    hzd_slot_t           id_slot;
    hzd_slot_t           slot_in [NSLOT];
    hzd_slot_t           slot_q  [NSLOT];
    logic [NSLOT-1:0]    bubble;
    logic [WAIT_W-1:0]   wait_cnt_q;
    logic [WAIT_W-1:0]   wait_cnt_d;
    halt_state_t         halt_state_q;
    halt_state_t         halt_state_d;
    logic                stall_all;
    logic                flush;
    logic                load_use;
    logic                pipe_empty;
    logic                unused_wb;

    always_comb begin
        id_slot      = '0;
        id_slot.v    = i_issue_valid && i_reg_wr_en_ID && (i_reg_sel_ID != '0);
        id_slot.rd   = HZD_REG_W_MAX'(i_reg_sel_ID);
        id_slot.load = i_is_load_ID;
    end

    assign load_use = i_issue_valid && slot_q[S_EX].load &&
                      ((i_use_rs && slot_writes(slot_q[S_EX], HZD_REG_W_MAX'(i_rs_ID))) ||
                       (i_use_rt && slot_writes(slot_q[S_EX], HZD_REG_W_MAX'(i_rt_ID))));

    // Priority: memory wait freezes everything, then flush, then load-use.
    assign stall_all = (wait_cnt_q != '0);
    assign flush     = i_branch_taken_EX && !stall_all;

    assign o_stall_all   = stall_all;
    assign o_flush_IF_ID = flush;
    assign o_flush_ID_EX = flush;
    assign o_stall_ID    = load_use && !flush && !stall_all;

    assign bubble = {{(NSLOT-1){1'b0}}, o_stall_ID || flush};

    genvar gi;
    generate
        for (gi = 0; gi < NSLOT; gi++) begin : g_slot
            if (gi == 0) begin : g_head
                assign slot_in[gi] = id_slot;
            end else begin : g_chain
                assign slot_in[gi] = slot_q[gi-1];
            end

            hazard_track_slot u_slot (
                .i_clk    (i_clk),
                .i_reset  (i_reset),
                .i_hold   (stall_all),
                .i_bubble (bubble[gi]),
                .i_slot   (slot_in[gi]),
                .o_slot   (slot_q[gi])
            );
        end
    endgenerate

    // The WB slot is only consulted for occupancy during drain.
    assign unused_wb = ^{slot_q[S_WB].rd, slot_q[S_WB].load};

    // A load entering MEM holds it for MEM_LAT cycles in total.
    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (stall_all) begin
            wait_cnt_d = wait_cnt_q - WAIT_W'(1);
        end else if (slot_q[S_EX].v && slot_q[S_EX].load) begin
            wait_cnt_d = WAIT_W'(MEM_LAT - 1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            wait_cnt_q <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end

    assign pipe_empty = !slot_q[S_EX].v && !slot_q[S_MEM].v && !slot_q[S_WB].v &&
                        !stall_all && !i_issue_valid;

    always_comb begin
        halt_state_d = halt_state_q;
        case (halt_state_q)
            HALT_RUN: begin
                if (i_halt_req) halt_state_d = HALT_DRAIN;
            end
            HALT_DRAIN: begin
                if (!i_halt_req)     halt_state_d = HALT_RUN;
                else if (pipe_empty) halt_state_d = HALT_HALTED;
            end
            HALT_HALTED: begin
                if (!i_halt_req) halt_state_d = HALT_RUN;
            end
            default: halt_state_d = HALT_RUN;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            halt_state_q <= HALT_RUN;
        end else begin
            halt_state_q <= halt_state_d;
        end
    end

    assign o_fetch_hold = (halt_state_q != HALT_RUN);
    assign o_halt_ack   = (halt_state_q == HALT_HALTED);

`ifdef HAZARD_STATS_EN
    logic [31:0] stall_cycles_q;
    logic [31:0] stall_cycles_d;
    logic [31:0] flush_count_q;
    logic [31:0] flush_count_d;

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        flush_count_d  = flush_count_q;
        if ((o_stall_ID || stall_all) && (stall_cycles_q != '1)) begin
            stall_cycles_d = stall_cycles_q + 32'd1;
        end
        if (flush && (flush_count_q != '1)) begin
            flush_count_d = flush_count_q + 32'd1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            stall_cycles_q <= '0;
            flush_count_q  <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
            flush_count_q  <= flush_count_d;
        end
    end

    assign o_stall_cycles = stall_cycles_q;
    assign o_flush_count  = flush_count_q;
`endif

endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed scoreboard bench for hazard_control_unit with MEM_LAT=1 and MEM_LAT=3 instances.
module tb_hazard_control_unit;

    logic       clk = 1'b0;
    logic       i_reset;
    logic       i_issue_valid;
    logic [4:0] i_rs_ID;
    logic [4:0] i_rt_ID;
    logic       i_use_rs;
    logic       i_use_rt;
    logic       i_reg_wr_en_ID;
    logic [4:0] i_reg_sel_ID;
    logic       i_is_load_ID;
    logic       i_branch_taken_EX;
    logic       i_halt_req;

    logic o1_stall_ID, o1_stall_all, o1_flush_IF_ID, o1_flush_ID_EX, o1_fetch_hold, o1_halt_ack;
    logic o3_stall_ID, o3_stall_all, o3_flush_IF_ID, o3_flush_ID_EX, o3_fetch_hold, o3_halt_ack;
`ifdef HAZARD_STATS_EN
    logic [31:0] o1_stall_cycles, o1_flush_count, o3_stall_cycles, o3_flush_count;
`endif

    always #5 clk = ~clk;

    hazard_control_unit #(.MEM_LAT(1), .REG_W(5)) dut1 (
        .i_clk(clk), .i_reset(i_reset), .i_issue_valid(i_issue_valid),
        .i_rs_ID(i_rs_ID), .i_rt_ID(i_rt_ID), .i_use_rs(i_use_rs), .i_use_rt(i_use_rt),
        .i_reg_wr_en_ID(i_reg_wr_en_ID), .i_reg_sel_ID(i_reg_sel_ID), .i_is_load_ID(i_is_load_ID),
        .i_branch_taken_EX(i_branch_taken_EX), .i_halt_req(i_halt_req),
        .o_stall_ID(o1_stall_ID), .o_stall_all(o1_stall_all), .o_flush_IF_ID(o1_flush_IF_ID),
        .o_flush_ID_EX(o1_flush_ID_EX), .o_fetch_hold(o1_fetch_hold), .o_halt_ack(o1_halt_ack)
`ifdef HAZARD_STATS_EN
        , .o_stall_cycles(o1_stall_cycles), .o_flush_count(o1_flush_count)
`endif
    );

    hazard_control_unit #(.MEM_LAT(3), .REG_W(5)) dut3 (
        .i_clk(clk), .i_reset(i_reset), .i_issue_valid(i_issue_valid),
        .i_rs_ID(i_rs_ID), .i_rt_ID(i_rt_ID), .i_use_rs(i_use_rs), .i_use_rt(i_use_rt),
        .i_reg_wr_en_ID(i_reg_wr_en_ID), .i_reg_sel_ID(i_reg_sel_ID), .i_is_load_ID(i_is_load_ID),
        .i_branch_taken_EX(i_branch_taken_EX), .i_halt_req(i_halt_req),
        .o_stall_ID(o3_stall_ID), .o_stall_all(o3_stall_all), .o_flush_IF_ID(o3_flush_IF_ID),
        .o_flush_ID_EX(o3_flush_ID_EX), .o_fetch_hold(o3_fetch_hold), .o_halt_ack(o3_halt_ack)
`ifdef HAZARD_STATS_EN
        , .o_stall_cycles(o3_stall_cycles), .o_flush_count(o3_flush_count)
`endif
    );

    // Observed vector: {stall_ID, stall_all, flush_IF_ID, flush_ID_EX, fetch_hold, halt_ack}
    logic [5:0] obs1, obs3;
    assign obs1 = {o1_stall_ID, o1_stall_all, o1_flush_IF_ID, o1_flush_ID_EX, o1_fetch_hold, o1_halt_ack};
    assign obs3 = {o3_stall_ID, o3_stall_all, o3_flush_IF_ID, o3_flush_ID_EX, o3_fetch_hold, o3_halt_ack};

    localparam logic [5:0] Z = 6'b000000;
    localparam logic [5:0] S = 6'b100000;
    localparam logic [5:0] A = 6'b010000;
    localparam logic [5:0] F = 6'b001100;
    localparam logic [5:0] H = 6'b000010;
    localparam logic [5:0] K = 6'b000011;

    typedef struct {
        string      tag;
        bit         sel3;
        logic [5:0] exp;
    } exp_t;

    exp_t sb[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    task automatic expect_out(input string tag, input bit sel3, input logic [5:0] e);
        exp_t x;
        x.tag  = tag;
        x.sel3 = sel3;
        x.exp  = e;
        sb.push_back(x);
    endtask

    // Queue the expectation, let the inputs settle, drain the scoreboard, then advance one clock.
    task automatic step(input string tag, input bit sel3, input logic [5:0] e);
        exp_t       x;
        logic [5:0] obs;
        expect_out(tag, sel3, e);
        #3;
        while (sb.size() > 0) begin
            x   = sb.pop_front();
            obs = x.sel3 ? obs3 : obs1;
            n_cmp++;
            $display("step %-28s dut=%s observed=%b expected=%b", x.tag, x.sel3 ? "L3" : "L1", obs, x.exp);
            assert (obs === x.exp) else begin
                n_fail++;
                $error("FAIL %s observed=%b expected=%b", x.tag, obs, x.exp);
            end
        end
        @(posedge clk);
        #1;
    endtask

`ifdef HAZARD_STATS_EN
    task automatic cmp32(input string tag, input logic [31:0] obs, input logic [31:0] e);
        n_cmp++;
        $display("stat %-28s observed=%0d expected=%0d", tag, obs, e);
        assert (obs === e) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, e);
        end
    endtask
`endif

    task automatic id_set(input bit v, input int rs, input int rt, input bit urs, input bit urt,
                          input bit wr, input int sel, input bit ld);
        i_issue_valid  = v;
        i_rs_ID        = 5'(rs);
        i_rt_ID        = 5'(rt);
        i_use_rs       = urs;
        i_use_rt       = urt;
        i_reg_wr_en_ID = wr;
        i_reg_sel_ID   = 5'(sel);
        i_is_load_ID   = ld;
    endtask

    task automatic id_idle();
        id_set(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset(input string tag);
        i_reset           = 1'b1;
        i_branch_taken_EX = 1'b0;
        i_halt_req        = 1'b0;
        id_idle();
        @(posedge clk);
        #1;
        expect_out({tag, "_L3"}, 1'b1, Z);
        step({tag, "_L1"}, 1'b0, Z);
        i_reset = 1'b0;
    endtask

    initial begin
        i_reset = 1'b1;
        i_branch_taken_EX = 1'b0;
        i_halt_req = 1'b0;
        id_idle();

        // Load-use detection, MEM_LAT=1
        do_reset("reset_a");
        id_set(1, 0, 0, 0, 0, 1, 2, 1);  step("lu_lw2_issue", 0, Z);
        id_set(1, 2, 4, 1, 1, 1, 3, 0);  step("lu_stall", 0, S);
        step("lu_bubble_clear", 0, Z);
        id_idle();                       step("lu_idle", 0, Z);
        id_set(1, 0, 0, 0, 0, 1, 0, 1);  step("lw0_issue", 0, Z);
        id_set(1, 0, 0, 1, 1, 1, 3, 0);  step("lw0_read_r0", 0, Z);
        id_set(1, 0, 0, 0, 0, 1, 5, 1);  step("lw5_issue", 0, Z);
        id_set(1, 1, 5, 1, 0, 1, 3, 0);  step("lw5_rt_unused", 0, Z);
        id_set(1, 0, 0, 0, 0, 1, 6, 1);  step("lw6_issue", 0, Z);
        id_set(1, 1, 6, 0, 1, 1, 3, 0);  step("lw6_rt_stall", 0, S);
        step("lw6_after", 0, Z);
        id_set(1, 0, 0, 0, 0, 1, 7, 1);  step("lw7_issue", 0, Z);
        id_set(1, 7, 0, 1, 0, 1, 3, 0);
        i_branch_taken_EX = 1'b1;        step("br_over_stall", 0, F);
        i_branch_taken_EX = 1'b0;
        id_idle();                       step("br_after", 0, Z);
`ifdef HAZARD_STATS_EN
        cmp32("stats_stall_cycles", o1_stall_cycles, 32'd2);
        cmp32("stats_flush_count", o1_flush_count, 32'd1);
`endif

        // Multi-cycle load wait, MEM_LAT=3
        do_reset("reset_b");
        id_set(1, 0, 0, 0, 0, 1, 9, 1);  step("m3_lw9", 1, Z);
        id_set(1, 0, 0, 0, 0, 1, 11, 1); step("m3_lw11", 1, Z);
        id_set(1, 11, 0, 1, 0, 1, 3, 0);
        i_branch_taken_EX = 1'b1;        step("m3_wait1_flush_masked", 1, A);
        i_branch_taken_EX = 1'b0;        step("m3_wait2", 1, A);
        step("m3_frozen_ex_stall", 1, S);
        step("m3_lw11_wait1", 1, A);
        step("m3_lw11_wait2", 1, A);
        id_idle();                       step("m3_release", 1, Z);

        // Halt drain with three valid slots
        do_reset("reset_c");
        id_set(1, 0, 0, 0, 0, 1, 1, 0);  step("h_fill1", 0, Z);
        id_set(1, 0, 0, 0, 0, 1, 2, 0);  step("h_fill2", 0, Z);
        id_set(1, 0, 0, 0, 0, 1, 3, 0);  step("h_fill3", 0, Z);
        id_idle();
        i_halt_req = 1'b1;               step("h_req_seen", 0, Z);
        step("h_drain1", 0, H);
        step("h_drain2", 0, H);
        step("h_drain_empty", 0, H);
        step("h_halted", 0, K);
        i_halt_req = 1'b0;               step("h_halted_drop", 0, K);
        step("h_run", 0, Z);

        // Request dropped before the pipe empties
        id_set(1, 0, 0, 0, 0, 1, 1, 0);
        i_halt_req = 1'b1;               step("e_req", 0, Z);
        step("e_drain_busy", 0, H);
        i_halt_req = 1'b0;               step("e_drain_drop", 0, H);
        step("e_run", 0, Z);

        // Reset in the middle of a drain
        id_idle();
        i_halt_req = 1'b1;               step("r_req", 0, Z);
        step("r_drain", 0, H);
        i_reset = 1'b1;                  step("r_reset_asserted", 0, H);
        i_reset = 1'b0;
        i_halt_req = 1'b0;               step("r_after_reset", 0, Z);
        step("r_idle", 0, Z);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
